// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo
//   Sample buffer between the op decoder and the I2S sender, on mon_clk.
//   Stores 32-bit stereo words (L=[31:16], R=[15:0]) and pops one per I2S
//   frame request, returning silence when no data is available. Also drives
//   the sample request mode and credit-based request ticks to the host.
//
// Ports
//   mon_clk, reset        sole clock, synchronous active-high reset
//   wr_valid, wr_data     sample word push (pulse)
//   audio_starts          host started audio (pulse)
//   end_audio_sample      host ended audio (pulse)
//   rd_req                I2S frame needs a word (pulse)
//   rd_data, rd_valid     word presented one cycle after rd_req
//   level, empty, full    occupancy
//   request_mode          1 while filling or playing
//   request_tick          ask host for one sample (pulse)
//   overflow, underflow   dropped write / starved read (pulse)
//   ovf_count, unf_count  saturating event counters
//
// Build option
//   AUDIO_FIFO_STATS_EN   when defined, builds the ovf/unf counters;
//                         otherwise both counters are tied to 0.
module audio_sample_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4,
    parameter int unsigned PRIME      = 8,
    parameter int unsigned HIGH_WATER = 12
) (
    input  logic          mon_clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [31:0]   wr_data,
    input  logic          audio_starts,
    input  logic          end_audio_sample,
    input  logic          rd_req,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          request_mode,
    output logic          request_tick,
    output logic          overflow,
    output logic          underflow,
    output logic [15:0]   ovf_count,
    output logic [15:0]   unf_count
);
    localparam int unsigned DW = 32;
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = AW + 2;

    typedef enum logic [1:0] {IDLE, FILL, PLAY, DRAIN} state_t;

    state_t        state;
    state_t        state_next;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] pending;

    logic          is_empty;
    logic          is_full;
    logic          can_read;
    logic          active;
    logic          active_next;
    logic          pop;
    logic          push;
    logic          drop;
    logic          starve;
    logic          tick;
    logic [LW-1:0] level_next;
    logic [LW-1:0] pending_dec;

    // Datapath decisions from registered occupancy
    assign is_empty    = (level == '0);
    assign is_full     = (level == LW'(DEPTH));
    assign can_read    = (state == PLAY) || (state == DRAIN);
    assign active      = (state == FILL) || (state == PLAY);
    assign active_next = (state_next == FILL) || (state_next == PLAY);
    assign pop         = rd_req && can_read && !is_empty;
    // A simultaneous pop frees the slot, so a write into a full FIFO survives
    assign push        = wr_valid && (!is_full || pop);
    assign drop        = wr_valid && is_full && !pop;
    assign starve      = rd_req && can_read && is_empty;
    // No tick on the edge that leaves FILL/PLAY
    assign tick        = active && active_next &&
                         ((SW'(level) + SW'(pending)) < SW'(HIGH_WATER));
    assign pending_dec = (push && (pending != '0)) ? (pending - LW'(1)) : pending;

    // Occupancy after this edge
    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    // State register
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; end_audio_sample takes priority over audio_starts
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (audio_starts && !end_audio_sample) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (end_audio_sample) begin
                    state_next = DRAIN;
                end else if (level >= LW'(PRIME)) begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (end_audio_sample) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (audio_starts && !end_audio_sample) begin
                    state_next = FILL;
                end else if (is_empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointers, occupancy, read port, pulses and credits
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            request_mode <= 1'b0;
            request_tick <= 1'b0;
            pending      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level     <= level_next;
            empty     <= (level_next == '0);
            full      <= (level_next == LW'(DEPTH));
            rd_valid  <= rd_req;
            if (rd_req) begin
                rd_data <= pop ? mem[rd_ptr] : '0;
            end
            overflow     <= drop;
            underflow    <= starve;
            request_mode <= active;
            request_tick <= tick;
            if (!active_next) begin
                pending <= '0;
            end else begin
                pending <= pending_dec + LW'(tick);
            end
        end
    end

    // Sample storage (contents need no reset)
    always_ff @(posedge mon_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef AUDIO_FIFO_STATS_EN
    // Saturating event counters, cleared only by reset
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else begin
            if (drop && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 16'd1;
            end
            if (starve && (unf_count != 16'hFFFF)) begin
                unf_count <= unf_count + 16'd1;
            end
        end
    end
`else
    assign ovf_count = '0;
    assign unf_count = '0;
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
module tb_audio_sample_fifo;
    localparam int DEPTH      = 16;
    localparam int PRIME      = 8;
    localparam int HIGH_WATER = 12;
    localparam int S_IDLE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_PLAY  = 2;
    localparam int S_DRAIN = 3;

    logic        mon_clk;
    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        audio_starts;
    logic        end_audio_sample;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [4:0]  level;
    logic        empty;
    logic        full;
    logic        request_mode;
    logic        request_tick;
    logic        overflow;
    logic        underflow;
    logic [15:0] ovf_count;
    logic [15:0] unf_count;

    audio_sample_fifo dut (
        .mon_clk          (mon_clk),
        .reset            (reset),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .audio_starts     (audio_starts),
        .end_audio_sample (end_audio_sample),
        .rd_req           (rd_req),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .level            (level),
        .empty            (empty),
        .full             (full),
        .request_mode     (request_mode),
        .request_tick     (request_tick),
        .overflow         (overflow),
        .underflow        (underflow),
        .ovf_count        (ovf_count),
        .unf_count        (unf_count)
    );

    initial begin
        mon_clk = 1'b0;
        forever #5 mon_clk = ~mon_clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of words plus the host-facing bookkeeping
    logic [31:0] q[$];
    int          m_state;
    int          m_pending;
    logic [31:0] e_rd_data;
    bit          e_rd_valid, e_ovf, e_unf, e_tick, e_mode;
    int          e_ovf_cnt, e_unf_cnt;

    function automatic bit is_active(input int s);
        return (s == S_FILL) || (s == S_PLAY);
    endfunction

    task automatic model_step(input bit rst, input bit wv, input logic [31:0] wd,
                              input bit as_, input bit eas, input bit rr);
        int lvl;
        int nxt;
        bit reading, popping, pushing;
        if (rst) begin
            q.delete();
            m_state = S_IDLE; m_pending = 0;
            e_rd_data = 0; e_rd_valid = 0; e_ovf = 0; e_unf = 0;
            e_tick = 0; e_mode = 0; e_ovf_cnt = 0; e_unf_cnt = 0;
            return;
        end
        lvl     = q.size();
        reading = (m_state == S_PLAY) || (m_state == S_DRAIN);
        popping = rr && reading && (lvl > 0);
        pushing = wv && ((lvl < DEPTH) || popping);
        nxt = m_state;
        if (m_state == S_IDLE && as_ && !eas) nxt = S_FILL;
        else if (m_state == S_FILL && eas) nxt = S_DRAIN;
        else if (m_state == S_FILL && lvl >= PRIME) nxt = S_PLAY;
        else if (m_state == S_PLAY && eas) nxt = S_DRAIN;
        else if (m_state == S_DRAIN && as_ && !eas) nxt = S_FILL;
        else if (m_state == S_DRAIN && lvl == 0) nxt = S_IDLE;
        e_tick = is_active(m_state) && is_active(nxt) && (lvl + m_pending < HIGH_WATER);
        if (!is_active(nxt)) m_pending = 0;
        else begin
            if (pushing && m_pending > 0) m_pending--;
            if (e_tick) m_pending++;
        end
        e_mode     = is_active(m_state);
        e_rd_valid = rr;
        if (rr) e_rd_data = popping ? q[0] : 32'h0;
        e_ovf = wv && !pushing;
        e_unf = rr && reading && (lvl == 0);
`ifdef AUDIO_FIFO_STATS_EN
        if (e_ovf && e_ovf_cnt < 65535) e_ovf_cnt++;
        if (e_unf && e_unf_cnt < 65535) e_unf_cnt++;
`endif
        if (popping) void'(q.pop_front());
        if (pushing) q.push_back(wd);
        m_state = nxt;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("m_rd_data", rd_data, e_rd_data);
        cmp("m_rd_valid", 32'(rd_valid), 32'(e_rd_valid));
        cmp("m_level", 32'(level), 32'(q.size()));
        cmp("m_empty", 32'(empty), 32'(q.size() == 0));
        cmp("m_full", 32'(full), 32'(q.size() == DEPTH));
        cmp("m_request_mode", 32'(request_mode), 32'(e_mode));
        cmp("m_request_tick", 32'(request_tick), 32'(e_tick));
        cmp("m_overflow", 32'(overflow), 32'(e_ovf));
        cmp("m_underflow", 32'(underflow), 32'(e_unf));
        cmp("m_ovf_count", 32'(ovf_count), 32'(e_ovf_cnt));
        cmp("m_unf_count", 32'(unf_count), 32'(e_unf_cnt));
    endtask

    // Called at a falling edge: drive, clock once, sample at the next falling edge
    task automatic step(input bit rst, input bit wv, input logic [31:0] wd,
                        input bit as_, input bit eas, input bit rr);
        reset = rst; wr_valid = wv; wr_data = wd;
        audio_starts = as_; end_audio_sample = eas; rd_req = rr;
        model_step(rst, wv, wd, as_, eas, rr);
        @(posedge mon_clk);
        @(negedge mon_clk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 0);
    endtask

    typedef struct {
        bit          wv;
        logic [31:0] wd;
        bit          as_;
        bit          rr;
        int          exp_level;
        bit          exp_tick;
        bit          exp_mode;
        logic [31:0] exp_rdata;
        bit          exp_unf;
    } vec_t;

    vec_t vecs[24];

    initial begin
        logic [31:0] tail[5];
        int exp_o, exp_u;

        // Start-up and priming: audio_starts, 8 writes, then idle until credits run out
        vecs[0] = '{0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 0};
        for (int k = 1; k <= 8; k++)
            vecs[k] = '{1, 32'h0001_0001 * k, 0, 0, k, 1, 1, 32'h0, 0};
        vecs[9]  = '{0, 32'h0, 0, 0, 8, 1, 1, 32'h0, 0};
        vecs[10] = '{0, 32'h0, 0, 0, 8, 1, 1, 32'h0, 0};
        vecs[11] = '{0, 32'h0, 0, 0, 8, 1, 1, 32'h0, 0};
        vecs[12] = '{0, 32'h0, 0, 0, 8, 0, 1, 32'h0, 0};
        vecs[13] = '{0, 32'h0, 0, 0, 8, 0, 1, 32'h0, 0};
        // Play out all 8 in order, then one starved read
        for (int k = 1; k <= 8; k++)
            vecs[13 + k] = '{0, 32'h0, 0, 1, 8 - k, (k != 1), 1, 32'h0001_0001 * k, 0};
        vecs[22] = '{0, 32'h0, 0, 1, 0, 1, 1, 32'h0, 1};
        vecs[23] = '{0, 32'h0, 0, 0, 0, 0, 1, 32'h0, 0};

        reset = 1; wr_valid = 0; wr_data = 0; audio_starts = 0;
        end_audio_sample = 0; rd_req = 0;
        @(negedge mon_clk);
        step(1, 0, 32'h0, 0, 0, 0);
        step(1, 0, 32'h0, 0, 0, 0);
        cmp("reset_level", 32'(level), 32'd0);
        cmp("reset_empty", 32'(empty), 32'd1);
        cmp("reset_full", 32'(full), 32'd0);
        cmp("reset_rd_data", rd_data, 32'h0);
        cmp("reset_mode", 32'(request_mode), 32'd0);
        cmp("reset_tick", 32'(request_tick), 32'd0);
        cmp("reset_ovf_count", 32'(ovf_count), 32'd0);

        foreach (vecs[i]) begin
            step(0, vecs[i].wv, vecs[i].wd, vecs[i].as_, 0, vecs[i].rr);
            cmp($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            cmp($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_level == 0));
            cmp($sformatf("vec%0d_tick", i), 32'(request_tick), 32'(vecs[i].exp_tick));
            cmp($sformatf("vec%0d_mode", i), 32'(request_mode), 32'(vecs[i].exp_mode));
            cmp($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rdata);
            cmp($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].exp_unf));
        end

        // Fill to full, overflow, then write+read while full
        for (int i = 0; i < 16; i++) step(0, 1, 32'h100 + 32'(i), 0, 0, 0);
        cmp("fill_level", 32'(level), 32'd16);
        cmp("fill_full", 32'(full), 32'd1);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cmp("ovf_pulse", 32'(overflow), 32'd1);
        cmp("ovf_level", 32'(level), 32'd16);
        step(0, 1, 32'hCAFE_0001, 0, 0, 1);
        cmp("wr_rd_full_ovf", 32'(overflow), 32'd0);
        cmp("wr_rd_full_level", 32'(level), 32'd16);
        cmp("wr_rd_full_data", rd_data, 32'h100);

        // Down to 5 entries, end audio, drain to IDLE
        for (int i = 0; i < 11; i++) step(0, 0, 32'h0, 0, 0, 1);
        cmp("pre_drain_level", 32'(level), 32'd5);
        step(0, 0, 32'h0, 0, 1, 0);
        cmp("end_tick", 32'(request_tick), 32'd0);
        step(0, 0, 32'h0, 0, 0, 0);
        cmp("drain_mode", 32'(request_mode), 32'd0);
        cmp("drain_tick", 32'(request_tick), 32'd0);
        tail = '{32'h10C, 32'h10D, 32'h10E, 32'h10F, 32'hCAFE_0001};
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 32'h0, 0, 0, 1);
            cmp($sformatf("drain_rd%0d", i), rd_data, tail[i]);
            cmp($sformatf("drain_tick%0d", i), 32'(request_tick), 32'd0);
        end
        cmp("drained_empty", 32'(empty), 32'd1);
        step(0, 0, 32'h0, 0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 1);
        cmp("idle_rd_valid", 32'(rd_valid), 32'd1);
        cmp("idle_rd_data", rd_data, 32'h0);
        cmp("idle_no_unf", 32'(underflow), 32'd0);

        // Reset in the middle of PLAY with 10 entries
        step(0, 0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 1, 32'h200 + 32'(i), 0, 0, 0);
        idle(2);
        step(0, 0, 32'h0, 0, 0, 1);
        cmp("play10_rd", rd_data, 32'h200);
        cmp("play10_level", 32'(level), 32'd10);
        step(1, 0, 32'h0, 0, 0, 0);
        cmp("rst_level", 32'(level), 32'd0);
        cmp("rst_rd_data", rd_data, 32'h0);
        cmp("rst_mode", 32'(request_mode), 32'd0);
        step(0, 0, 32'h0, 0, 0, 1);
        cmp("post_rst_rd", rd_data, 32'h0);
        cmp("post_rst_unf", 32'(underflow), 32'd0);

        // Counters: 3 overflows, 2 underflows
        step(0, 0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 1, 32'h300 + 32'(i), 0, 0, 0);
        for (int i = 0; i < 18; i++) step(0, 0, 32'h0, 0, 0, 1);
`ifdef AUDIO_FIFO_STATS_EN
        exp_o = 3; exp_u = 2;
`else
        exp_o = 0; exp_u = 0;
`endif
        cmp("ovf_count", 32'(ovf_count), 32'(exp_o));
        cmp("unf_count", 32'(unf_count), 32'(exp_u));

        // Randomised traffic against the model
        step(1, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            bit r_rst, r_wv, r_as, r_eas, r_rr;
            r_rst = ($urandom_range(0, 499) == 0);
            r_wv  = ($urandom_range(0, 99) < 50);
            r_rr  = ($urandom_range(0, 99) < 40);
            r_as  = ($urandom_range(0, 29) == 0);
            r_eas = ($urandom_range(0, 79) == 0);
            step(r_rst, r_wv, $urandom(), r_as, r_eas, r_rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
